// File: rtl/ddr_pixel_prefetch.sv
// DDR3 burst-read prefetcher feeding the 1280x720 video timing driver.
// Walks the frame buffer in fixed bursts and serves pixels from a show-ahead FIFO.
module ddr_pixel_prefetch #(
  parameter int BASE_ADDR    = 0,
  parameter int FRAME_PIXELS = 921600,
  parameter int BURST_LEN    = 64,
  parameter int FIFO_DEPTH   = 1024,
  parameter int PREFILL      = 512,
  parameter int ADDR_W       = 28
) (
  input  logic                          pixel_clk,
  input  logic                          sys_rst_n,
  input  logic                          ddr_init_done,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_ack,
  input  logic                          rd_data_vld,
  input  logic [15:0]                   rd_data,
  input  logic                          img_valid,
  output logic [15:0]                   pixel_data,
  output logic                          show_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int PEND_W = $clog2(BURST_LEN) + 1;

  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(BASE_ADDR + FRAME_PIXELS - BURST_LEN);
  localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  DEPTH_L    = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  PREFILL_L  = LVL_W'(PREFILL);
  localparam logic [PEND_W-1:0] BURST_P    = PEND_W'(BURST_LEN);
  localparam logic [LVL_W:0]    ROOM_LIMIT = (LVL_W+1)'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN} state_t;

  state_t            state, state_nxt;
  logic              show_en_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [PEND_W-1:0] pending_beats;
  logic              ack_seen;
  logic [15:0]       mem [FIFO_DEPTH];

  logic              active, ack_take, beat_take;
  logic              fifo_full, fifo_empty, wr_en, pop, req_ok;
  logic [LVL_W:0]    committed;

  // Beats only count once a request has been accepted since the last reset,
  // so leftovers from an aborted burst never land in the FIFO.
  assign active     = (state != IDLE);
  assign fifo_full  = (level == DEPTH_L);
  assign fifo_empty = (level == '0);
  assign ack_take   = active && rd_req && rd_ack;
  assign beat_take  = active && ack_seen && rd_data_vld;
  assign wr_en      = beat_take && !fifo_full;
  assign pop        = img_valid && !fifo_empty;
  assign committed  = {1'b0, level} + (LVL_W+1)'(pending_beats);
  assign req_ok     = active && !rd_req && (pending_beats == '0) && (committed <= ROOM_LIMIT);

  assign pixel_data = fifo_empty ? 16'h0000 : mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      show_en <= 1'b0;
    end else begin
      state   <= state_nxt;
      show_en <= show_en_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    show_en_nxt = show_en;
    case (state)
      IDLE:     if (ddr_init_done) state_nxt = PREFETCH;
      PREFETCH: begin
        if (level >= PREFILL_L) begin
          state_nxt   = RUN;
          show_en_nxt = 1'b1;
        end
      end
      RUN:      state_nxt = RUN;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request side: one burst in flight at most, FIFO space reserved at request time.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_req        <= 1'b0;
      rd_addr       <= BASE_A;
      pending_beats <= '0;
      ack_seen      <= 1'b0;
    end else if (ack_take) begin
      rd_req        <= 1'b0;
      pending_beats <= BURST_P;
      ack_seen      <= 1'b1;
      rd_addr       <= (rd_addr == LAST_A) ? BASE_A : rd_addr + STEP_A;
    end else begin
      if (req_ok)
        rd_req <= 1'b1;
      if (beat_take && (pending_beats != '0))
        pending_beats <= pending_beats - PEND_W'(1);
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (img_valid && fifo_empty)
        underflow <= 1'b1;
      if (beat_take && fifo_full)
        overflow <= 1'b1;
    end
  end

  // Storage has no reset; emptiness is tracked entirely by the pointers and level.
  always_ff @(posedge pixel_clk) begin
    if (wr_en)
      mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_ddr_pixel_prefetch.sv
// Bench for ddr_pixel_prefetch: small frame geometry, DDR responder, queue-based reference model.
module tb_ddr_pixel_prefetch;

  localparam int BASE  = 96;
  localparam int FRAME = 64;
  localparam int BURST = 8;
  localparam int DEPTH = 32;
  localparam int PRE   = 16;
  localparam int AW    = 28;
  localparam int LW    = 6;
  localparam int LAST  = BASE + FRAME - BURST;

  logic          pixel_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          ddr_init_done = 1'b0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack = 1'b0;
  logic          rd_data_vld = 1'b0;
  logic [15:0]   rd_data = 16'h0000;
  logic          img_valid = 1'b0;
  logic [15:0]   pixel_data;
  logic          show_en;
  logic [LW-1:0] fifo_level;
  logic          underflow;
  logic          overflow;

  always #5 pixel_clk = ~pixel_clk;

  ddr_pixel_prefetch #(
    .BASE_ADDR(BASE), .FRAME_PIXELS(FRAME), .BURST_LEN(BURST),
    .FIFO_DEPTH(DEPTH), .PREFILL(PRE), .ADDR_W(AW)
  ) dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .ddr_init_done(ddr_init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data), .img_valid(img_valid),
    .pixel_data(pixel_data), .show_en(show_en), .fifo_level(fifo_level),
    .underflow(underflow), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired before the awaited event", name);
  endtask

  // Reference model: FIFO as a queue, flags and expected address from the rules.
  logic [15:0] m_q[$];
  bit          m_started, m_ack_seen, m_show, m_uf, m_of;
  int          m_pend = 0;
  int          m_exp_addr = BASE;
  int          m_pops = 0;

  initial forever begin
    @(posedge pixel_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      m_q.delete();
      m_started = 0; m_ack_seen = 0; m_show = 0; m_uf = 0; m_of = 0;
      m_pend = 0; m_exp_addr = BASE;
    end else begin
      automatic bit full_now = (m_q.size() == DEPTH);
      if (m_started && !m_show && m_q.size() >= PRE) m_show = 1;
      if (img_valid) begin
        if (m_q.size() > 0) begin
          void'(m_q.pop_front());
          m_pops++;
        end else m_uf = 1;
      end
      if (m_started && m_ack_seen && rd_data_vld) begin
        if (full_now) m_of = 1;
        else m_q.push_back(rd_data);
        if (m_pend > 0) m_pend--;
      end
      if (m_started && rd_ack) begin
        m_ack_seen = 1;
        m_pend = BURST;
        m_exp_addr = (m_exp_addr + BURST == BASE + FRAME) ? BASE : m_exp_addr + BURST;
      end
      if (!m_started && ddr_init_done) m_started = 1;
    end
  end

  // Compare process: every negedge, DUT outputs against the model.
  bit            chk_en = 0;
  bit            req_prev = 0;
  logic [AW-1:0] addr_prev = '0;
  int            seq_exp = BASE;
  int            ack_log[$];

  initial forever begin
    @(negedge pixel_clk);
    if (chk_en) begin
      checkOutput("fifo_level", fifo_level, m_q.size());
      checkOutput("pixel_data", pixel_data, (m_q.size() > 0) ? m_q[0] : 16'h0000);
      checkOutput("show_en", show_en, m_show);
      checkOutput("underflow", underflow, m_uf);
      checkOutput("overflow", overflow, m_of);
      if (!m_started || m_pend != 0) checkOutput("rd_req_idle_or_pending", rd_req, 0);
      if (rd_req && !req_prev) checkOutput("req_space_ok", (DEPTH - m_q.size() - m_pend) >= BURST, 1);
      if (rd_req && req_prev) checkOutput("rd_addr_stable", rd_addr, addr_prev);
      if (rd_req && rd_ack) begin
        checkOutput("ack_addr", rd_addr, m_exp_addr);
        ack_log.push_back(int'(rd_addr));
      end
      if (!sys_rst_n) begin
        checkOutput("reset_rd_addr", rd_addr, BASE);
        seq_exp = BASE;
      end else if (img_valid && m_q.size() > 0) begin
        checkOutput("pixel_seq", pixel_data, seq_exp);
        seq_exp = (seq_exp + 1 == BASE + FRAME) ? BASE : seq_exp + 1;
      end
      req_prev  = rd_req;
      addr_prev = rd_addr;
    end
  end

  // DDR responder and driver-side img_valid, updated 1 time unit after each edge.
  int          cyc = 0;
  int          req_age = 0;
  int          beats_left = 0;
  logic [31:0] beat_addr = '0;
  int          iv_mode = 0;
  bit          ddr_stall = 0;
  bit          inject_beat = 0;
  bit          inject_ack = 0;

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
      rd_ack = 1'b0;
      rd_data_vld = 1'b0;
      if (inject_ack) begin
        rd_ack = 1'b1;
        inject_ack = 0;
      end
      if (inject_beat) begin
        rd_data_vld = 1'b1;
        rd_data = 16'hBEEF;
        inject_beat = 0;
      end else if (beats_left > 0 && !ddr_stall) begin
        rd_data_vld = 1'b1;
        rd_data = beat_addr[15:0];
        beat_addr = beat_addr + 1;
        beats_left--;
      end else if (rd_req && beats_left == 0) begin
        req_age++;
        if (req_age == 3) begin
          rd_ack = 1'b1;
          beats_left = BURST;
          beat_addr = 32'(rd_addr);
          req_age = 0;
        end
      end
      if (!rd_req) req_age = 0;
      case (iv_mode)
        1:       img_valid = show_en && (cyc % 3 == 0);
        2:       img_valid = 1'b1;
        default: img_valid = 1'b0;
      endcase
      cyc++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_req"}, rd_req, 0);
    checkOutput({tag, "_rd_addr"}, rd_addr, BASE);
    checkOutput({tag, "_show_en"}, show_en, 0);
    checkOutput({tag, "_fifo_level"}, fifo_level, 0);
    checkOutput({tag, "_underflow"}, underflow, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
    checkOutput({tag, "_pixel_data"}, pixel_data, 0);
  endtask

  initial begin
    int hit_cyc, hit_lvl, show_cyc, ack_mark;
    bit wrap_seen;

    #2 sys_rst_n = 1'b0;
    chk_en = 1;
    applyStimulus(3);
    checkResetValues("reset");
    sys_rst_n = 1'b1;

    // Stray ack and beat while still idle must be ignored.
    inject_ack = 1;
    inject_beat = 1;
    applyStimulus(4);
    checkOutput("idle_level", fifo_level, 0);
    checkOutput("idle_req", rd_req, 0);

    $display("[TB] T1 startup");
    ddr_init_done = 1'b1;
    iv_mode = 1;
    hit_cyc = -1; hit_lvl = -1; show_cyc = -1;
    for (int i = 0; i < 400 && show_cyc < 0; i++) begin
      applyStimulus(1);
      if (hit_cyc < 0 && fifo_level >= PRE) begin
        hit_cyc = cyc;
        hit_lvl = int'(fifo_level);
      end
      if (show_en) show_cyc = cyc;
    end
    if (show_cyc < 0) reportTimeout("t1_show_en");
    else begin
      checkOutput("t1_prefill_level", hit_lvl, PRE);
      checkOutput("t1_show_latency", show_cyc - hit_cyc, 1);
    end
    checkOutput("t1_ack_count_ge2", ack_log.size() >= 2, 1);
    checkOutput("t1_first_addr", ack_log[0], 96);
    checkOutput("t1_second_addr", ack_log[1], 104);

    $display("[TB] T2 steady state");
    for (int i = 0; i < 3000 && m_pops < 2 * FRAME + 8; i++) applyStimulus(1);
    if (m_pops < 2 * FRAME + 8) reportTimeout("t2_two_frames");
    wrap_seen = 0;
    for (int i = 0; i + 1 < ack_log.size(); i++)
      if (ack_log[i] == LAST && ack_log[i+1] == BASE) wrap_seen = 1;
    checkOutput("t2_addr_wrap", wrap_seen, 1);
    checkOutput("t2_underflow", underflow, 0);
    checkOutput("t2_overflow", overflow, 0);

    $display("[TB] T3 backpressure");
    for (int i = 0; i < 100 && (m_pops % BURST) != 0; i++) applyStimulus(1);
    iv_mode = 0;
    img_valid = 1'b0;
    applyStimulus(80);
    checkOutput("t3_level_full", fifo_level, 32);
    checkOutput("t3_no_req", rd_req, 0);
    checkOutput("t3_overflow", overflow, 0);

    $display("[TB] T5 overflow");
    inject_beat = 1;
    applyStimulus(3);
    checkOutput("t5_overflow", overflow, 1);
    checkOutput("t5_level", fifo_level, 32);

    $display("[TB] T4 underflow");
    ddr_stall = 1;
    iv_mode = 2;
    applyStimulus(45);
    checkOutput("t4_level_empty", fifo_level, 0);
    checkOutput("t4_underflow", underflow, 1);
    checkOutput("t4_pixel_zero", pixel_data, 0);
    ddr_stall = 0;
    applyStimulus(60);
    checkOutput("t4_underflow_sticky", underflow, 1);

    $display("[TB] T6 reset mid-burst");
    iv_mode = 1;
    for (int i = 0; i < 200 && beats_left != BURST - 4; i++) applyStimulus(1);
    if (beats_left != BURST - 4) reportTimeout("t6_mid_burst");
    ack_mark = ack_log.size();
    sys_rst_n = 1'b0;
    applyStimulus(2);
    checkResetValues("t6");
    sys_rst_n = 1'b1;
    applyStimulus(3);
    checkOutput("t6_strays_ignored", fifo_level, 0);
    show_cyc = -1;
    for (int i = 0; i < 400 && show_cyc < 0; i++) begin
      applyStimulus(1);
      if (show_en) show_cyc = cyc;
    end
    if (show_cyc < 0) reportTimeout("t6_show_en");
    checkOutput("t6_ack_after_reset", ack_log.size() > ack_mark, 1);
    checkOutput("t6_restart_addr", ack_log[ack_mark], 96);
    applyStimulus(40);

    chk_en = 0;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
